pcg_stream_checker: RTL and testbench

//   Receive-side checker for the PCG-XSH-RR random stream. Holds its own 64-bit LCG

---
 rtl/pcg_stream_checker_if.sv | 14 +
 rtl/pcg_stream_checker.sv | 149 ++++++++++++++
 tb/tb_pcg_stream_checker.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcg_stream_checker_if.sv
// rtl/pcg_stream_checker_if.sv - received-word stream handshake into the PCG stream checker
//
// Purpose : groups the valid/ready handshake that carries generator words into the checker.
// Signals : in_valid  - in_data holds a received word (master -> slave)
//           in_data   - 32-bit received generator output word (master -> slave)
//           in_ready  - checker accepts a word this cycle (slave -> master)
interface pcg_stream_checker_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pcg_stream_checker.sv
// rtl/pcg_stream_checker.sv - PCG-XSH-RR receive-side stream checker with pass/error statistics
//
// Purpose : tracks a local 64-bit LCG seeded like the generator, predicts each 32-bit word,
//           compares it with the received word and keeps counters and a lock/fail state.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           in_if (slave)     - received word stream (in_valid/in_data/in_ready)
//           seed_load_i       - 1-cycle pulse: load seed_i, clear statistics, enter RUN
//           seed_i            - initial LCG state
//           chk_valid_o       - 1-cycle pulse: compare result valid
//           chk_pass_o        - last compared word matched the prediction
//           expected_o        - predicted word for the last compare
//           word_cnt_o        - words accepted since load (saturating)
//           err_cnt_o         - mismatches since load (saturating)
//           first_err_vld_o   - at least one mismatch since load
//           first_err_idx_o   - 0-based index of the first mismatching word
//           locked_o, fail_o  - FSM is in RUN / FAIL
module pcg_stream_checker #(
    parameter logic [63:0] MULT      = 64'h5851F42D4C957F2D,
    parameter logic [63:0] INC       = 64'h14057B7EF767814F,
    parameter int          ERR_LIMIT = 4,
    parameter int          CNT_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    pcg_stream_checker_if.slave in_if,
    input  logic                seed_load_i,
    input  logic [63:0]         seed_i,
    output logic                chk_valid_o,
    output logic                chk_pass_o,
    output logic [31:0]         expected_o,
    output logic [CNT_W-1:0]    word_cnt_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic                first_err_vld_o,
    output logic [CNT_W-1:0]    first_err_idx_o,
    output logic                locked_o,
    output logic                fail_o
);
    localparam int CON_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL} state_e;

    state_e             state_q, state_d;
    logic [63:0]        lcg_q, lcg_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   first_idx_q, first_idx_d;
    logic               first_vld_q, first_vld_d;
    logic [CON_W-1:0]   consec_q, consec_d;
    logic               chk_valid_q, chk_valid_d;
    logic               chk_pass_q, chk_pass_d;
    logic [31:0]        expected_q, expected_d;

    // XSH-RR output permutation of the current state: xorshift, truncate, then a
    // data-dependent right rotate by the top five state bits.
    logic [31:0] xsh;
    logic [4:0]  rot;
    logic [31:0] pred;
    logic        accept;
    logic        mismatch;

    assign xsh  = 32'((lcg_q ^ (lcg_q >> 18)) >> 27);
    assign rot  = lcg_q[63:59];
    assign pred = (xsh >> rot) | (xsh << (5'd0 - rot));

    // A seed_load cycle never accepts: the coincident word belongs to the old stream.
    assign in_if.in_ready = (state_q == S_RUN) & ~seed_load_i;
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign mismatch       = (in_if.in_data != pred);

    always_comb begin
        state_d     = state_q;
        lcg_d       = lcg_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        consec_d    = consec_q;
        chk_valid_d = 1'b0;
        chk_pass_d  = chk_pass_q;
        expected_d  = expected_q;

        if (seed_load_i) begin
            state_d     = S_RUN;
            lcg_d       = seed_i;
            word_cnt_d  = '0;
            err_cnt_d   = '0;
            first_idx_d = '0;
            first_vld_d = 1'b0;
            consec_d    = '0;
        end else if (accept) begin
            expected_d  = pred;
            chk_pass_d  = ~mismatch;
            chk_valid_d = 1'b1;
            lcg_d       = lcg_q * MULT + INC;
            if (word_cnt_q != {CNT_W{1'b1}})
                word_cnt_d = word_cnt_q + CNT_W'(1);
            if (mismatch) begin
                if (err_cnt_q != {CNT_W{1'b1}})
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                if (!first_vld_q) begin
                    first_vld_d = 1'b1;
                    first_idx_d = word_cnt_q;
                end
                // consec cannot exceed ERR_LIMIT: reaching it leaves RUN.
                consec_d = consec_q + CON_W'(1);
                if (consec_d == CON_W'(ERR_LIMIT))
                    state_d = S_FAIL;
            end else begin
                consec_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lcg_q       <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            consec_q    <= '0;
            chk_valid_q <= 1'b0;
            chk_pass_q  <= 1'b0;
            expected_q  <= '0;
        end else begin
            state_q     <= state_d;
            lcg_q       <= lcg_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
            consec_q    <= consec_d;
            chk_valid_q <= chk_valid_d;
            chk_pass_q  <= chk_pass_d;
            expected_q  <= expected_d;
        end
    end

    assign chk_valid_o     = chk_valid_q;
    assign chk_pass_o      = chk_pass_q;
    assign expected_o      = expected_q;
    assign word_cnt_o      = word_cnt_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_vld_o = first_vld_q;
    assign first_err_idx_o = first_idx_q;
    assign locked_o        = (state_q == S_RUN);
    assign fail_o          = (state_q == S_FAIL);
endmodule

// File: tb/tb_pcg_stream_checker.sv
// tb/tb_pcg_stream_checker.sv - self-checking bench for pcg_stream_checker against a behavioural model
module tb_pcg_stream_checker;
    localparam logic [63:0] MULT = 64'h5851F42D4C957F2D;
    localparam logic [63:0] INC  = 64'h14057B7EF767814F;
    localparam int          LIM  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [63:0] seed;
    logic        chk_valid, chk_pass, first_err_vld, locked, fail;
    logic [31:0] expected, word_cnt, err_cnt, first_err_idx;

    always #5 clk = ~clk;

    pcg_stream_checker_if bus ();

    pcg_stream_checker dut (
        .clk             (clk),
        .rst             (rst),
        .in_if           (bus.slave),
        .seed_load_i     (seed_load),
        .seed_i          (seed),
        .chk_valid_o     (chk_valid),
        .chk_pass_o      (chk_pass),
        .expected_o      (expected),
        .word_cnt_o      (word_cnt),
        .err_cnt_o       (err_cnt),
        .first_err_vld_o (first_err_vld),
        .first_err_idx_o (first_err_idx),
        .locked_o        (locked),
        .fail_o          (fail)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: mode 0=idle 1=run 2=fail.
    int          m_mode;
    logic [63:0] m_state;
    logic [31:0] m_cnt, m_err, m_idx, m_exp;
    logic        m_vld1st, m_cv, m_pass, m_ready;
    int          m_consec;
    logic        ready_seen;
    logic [63:0] gen_state;

    function automatic logic [31:0] pcg_out(input logic [63:0] s);
        logic [63:0] x;
        logic [63:0] dbl;
        int          r;
        x   = (s ^ (s >> 18)) >> 27;
        r   = int'(s >> 59);
        dbl = {x[31:0], x[31:0]} >> r;
        return dbl[31:0];
    endfunction

    function automatic logic [31:0] gen_next();
        logic [31:0] w;
        w         = pcg_out(gen_state);
        gen_state = gen_state * MULT + INC;
        return w;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_state = '0; m_cnt = '0; m_err = '0; m_idx = '0; m_exp = '0;
        m_vld1st = 1'b0; m_cv = 1'b0; m_pass = 1'b0; m_consec = 0;
    endfunction

    function automatic logic [133:0] dut_vec();
        return {chk_valid, chk_pass, expected, word_cnt, err_cnt, first_err_vld,
                first_err_idx, locked, fail};
    endfunction

    function automatic logic [133:0] model_vec();
        return {m_cv, m_pass, m_exp, m_cnt, m_err, m_vld1st, m_idx,
                (m_mode == 1), (m_mode == 2)};
    endfunction

    // Drives one clock of stimulus starting at a negedge, advances the model,
    // and returns at the following negedge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic sl, input logic [63:0] sd);
        logic [31:0] p;
        bus.in_valid = v;
        bus.in_data  = d;
        seed_load    = sl;
        seed         = sd;
        #1 ready_seen = bus.in_ready;
        m_ready = (m_mode == 1) && !sl;
        m_cv    = 1'b0;
        if (sl) begin
            m_mode = 1; m_state = sd; m_cnt = '0; m_err = '0; m_idx = '0;
            m_vld1st = 1'b0; m_consec = 0;
        end else if (v && m_mode == 1) begin
            p      = pcg_out(m_state);
            m_exp  = p;
            m_pass = (d == p);
            m_cv   = 1'b1;
            m_state = m_state * MULT + INC;
            if (!m_pass) begin
                if (!m_vld1st) begin m_vld1st = 1'b1; m_idx = m_cnt; end
                if (m_err != 32'hFFFFFFFF) m_err = m_err + 1;
                m_consec++;
                if (m_consec == LIM) m_mode = 2;
            end else begin
                m_consec = 0;
            end
            if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        seed_load    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; seed_load = 1'b0; seed = '0; bus.in_valid = 1'b1; bus.in_data = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (dut_vec() !== '0 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got %h ready=%b want all zero", dut_vec(), bus.in_ready);
        end
        cycle(1'b1, 32'h0, 1'b0, '0);
        n_cmp++;
        if (ready_seen !== 1'b0 || word_cnt !== 32'd0 || chk_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_accept: ready=%b cnt=%0d cv=%b want 0/0/0", ready_seen, word_cnt, chk_valid);
        end
    endtask

    task automatic test_seed_zero();
        cycle(1'b0, 32'h0, 1'b1, 64'h0);
        cycle(1'b1, 32'h0, 1'b0, '0);
        n_cmp++;
        if ({chk_valid, chk_pass, expected, word_cnt, locked} !== {1'b1, 1'b1, 32'h0, 32'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL seed_zero: cv=%b pass=%b exp=%h cnt=%0d lock=%b want 1/1/0/1/1",
                     chk_valid, chk_pass, expected, word_cnt, locked);
        end
    endtask

    task automatic test_stream(input int corrupt_idx);
        logic [31:0] w;
        int i;
        gen_state = 64'hD4E12F77CAFEBABE;
        cycle(1'b0, 32'h0, 1'b1, gen_state);
        i = 0;
        while (i < 20) begin
            if ($urandom_range(3) == 0) begin
                cycle(1'b0, $urandom, 1'b0, '0);
                n_cmp++;
                if (chk_valid !== 1'b0 || expected !== m_exp) begin
                    n_bad++;
                    $display("FAIL stream_gap: cv=%b exp=%h want 0/%h", chk_valid, expected, m_exp);
                end
            end else begin
                w = gen_next();
                if (i == corrupt_idx) w = w ^ 32'h1;
                cycle(1'b1, w, 1'b0, '0);
                n_cmp++;
                if (chk_valid !== 1'b1 || chk_pass !== (i != corrupt_idx) || locked !== 1'b1
                    || expected !== m_exp) begin
                    n_bad++;
                    $display("FAIL stream_word%0d: cv=%b pass=%b lock=%b exp=%h want 1/%b/1/%h",
                             i, chk_valid, chk_pass, locked, expected, (i != corrupt_idx), m_exp);
                end
                i++;
            end
        end
        n_cmp++;
        if (word_cnt !== 32'd20 || err_cnt !== ((corrupt_idx >= 0) ? 32'd1 : 32'd0)
            || first_err_vld !== (corrupt_idx >= 0)
            || first_err_idx !== ((corrupt_idx >= 0) ? 32'(corrupt_idx) : 32'd0)) begin
            n_bad++;
            $display("FAIL stream_stats: cnt=%0d err=%0d fv=%b fi=%0d corrupt=%0d",
                     word_cnt, err_cnt, first_err_vld, first_err_idx, corrupt_idx);
        end
    endtask

    task automatic test_fail();
        cycle(1'b0, 32'h0, 1'b1, 64'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hFFFFFFFF, 1'b0, '0);
        n_cmp++;
        if (err_cnt !== 32'd4 || fail !== 1'b1 || locked !== 1'b0 || bus.in_ready !== 1'b0
            || first_err_idx !== 32'd0) begin
            n_bad++;
            $display("FAIL fail_enter: err=%0d fail=%b lock=%b ready=%b fi=%0d want 4/1/0/0/0",
                     err_cnt, fail, locked, bus.in_ready, first_err_idx);
        end
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, '0);
        n_cmp++;
        if (word_cnt !== 32'd4 || err_cnt !== 32'd4 || chk_valid !== 1'b0 || ready_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL fail_frozen: cnt=%0d err=%0d cv=%b ready=%b want 4/4/0/0",
                     word_cnt, err_cnt, chk_valid, ready_seen);
        end
        cycle(1'b0, 32'h0, 1'b1, 64'h1234);
        n_cmp++;
        if (locked !== 1'b1 || fail !== 1'b0 || word_cnt !== 32'd0 || err_cnt !== 32'd0
            || first_err_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL fail_reseed: lock=%b fail=%b cnt=%0d err=%0d fv=%b want 1/0/0/0/0",
                     locked, fail, word_cnt, err_cnt, first_err_vld);
        end
    endtask

    task automatic test_seed_collision();
        cycle(1'b0, 32'h0, 1'b1, 64'h77);
        cycle(1'b1, pcg_out(64'h77), 1'b1, 64'h77);
        n_cmp++;
        if (ready_seen !== 1'b0 || word_cnt !== 32'd0 || chk_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL seed_collision: ready=%b cnt=%0d cv=%b want 0/0/0", ready_seen, word_cnt, chk_valid);
        end
        cycle(1'b1, pcg_out(64'h77), 1'b0, '0);
        n_cmp++;
        if (chk_pass !== 1'b1 || word_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL seed_collision_next: pass=%b cnt=%0d want 1/1", chk_pass, word_cnt);
        end
    endtask

    task automatic test_async_reset();
        gen_state = 64'h0123456789ABCDEF;
        cycle(1'b0, 32'h0, 1'b1, gen_state);
        for (int i = 0; i < 10; i++) cycle(1'b1, gen_next(), 1'b0, '0);
        bus.in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== '0 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %h ready=%b want all zero", dut_vec(), bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h0, 1'b0, '0);
        n_cmp++;
        if (ready_seen !== 1'b0 || word_cnt !== 32'd0 || chk_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: ready=%b cnt=%0d cv=%b want 0/0/0", ready_seen, word_cnt, chk_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        v, sl;
        logic [63:0] sd;
        for (int n = 0; n < 400; n++) begin
            sl = ($urandom_range(29) == 0);
            sd = {$urandom, $urandom};
            v  = ($urandom_range(3) != 0);
            w  = $urandom;
            if (!sl && v && m_mode == 1) begin
                w = gen_next();
                if ($urandom_range(2) == 0) w = w ^ (32'h1 << $urandom_range(31));
            end
            if (sl) gen_state = sd;
            cycle(v, w, sl, sd);
            n_cmp++;
            if (dut_vec() !== model_vec() || ready_seen !== m_ready) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h ready=%b want %h ready=%b",
                         n, dut_vec(), ready_seen, model_vec(), m_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_seed_zero();
        test_stream(-1);
        test_stream(5);
        test_fail();
        test_seed_collision();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
